// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcodes and FSM state type for the fetch control slice.
package fetch_pkg;
    localparam int PC_W = 7;
    localparam int INST_W = 9;
    localparam int OFF_W = 5;
    localparam logic [3:0] OP_BRC = 4'b1110;
    localparam logic [3:0] OP_JMP = 4'b1101;
    localparam logic [INST_W-1:0] INST_HALT = 9'h1FF;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HALTED} ctrl_state_t;
endpackage

// File: rtl/inst_branch_decode.sv
// inst_branch_decode: combinational branch/halt decode of the current instruction word.
module inst_branch_decode
    import fetch_pkg::*;
#(
    parameter int INST_W = fetch_pkg::INST_W,
    parameter int OFF_W  = fetch_pkg::OFF_W
) (
    input  logic [INST_W-1:0] inst,
    input  logic              cond_flag,
    output logic              is_branch,
    output logic              is_taken,
    output logic              is_halt,
    output logic [OFF_W-1:0]  offset
);
    logic [3:0] op;
    always_comb begin
        op        = inst[INST_W-1 -: 4];
        is_halt   = inst == INST_HALT;
        is_branch = op == OP_BRC || op == OP_JMP;
        is_taken  = op == OP_JMP || (op == OP_BRC && cond_flag);
        offset    = inst[OFF_W-1:0];
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: launch / branch / halt sequencer driving the fetch unit for one program run.
// Optional FETCH_CTRL_PERF_EN adds saturating run_cycles and taken_count outputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W   = fetch_pkg::PC_W,
    parameter int INST_W = fetch_pkg::INST_W,
    parameter int OFF_W  = fetch_pkg::OFF_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              go,
    input  logic [PC_W-1:0]   program_base,
    input  logic [INST_W-1:0] inst,
    input  logic              cond_flag,
    output logic              start,
    output logic [PC_W-1:0]   start_address,
    output logic              branch,
    output logic              taken,
    output logic [OFF_W-1:0]  offset,
    output logic              halt,
    output logic              done
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0]       run_cycles,
    output logic [7:0]        taken_count
`endif
);
    ctrl_state_t     state_q, state_d;
    logic            go_q;
    logic [PC_W-1:0] base_q, base_d;
    logic            is_branch, is_taken, is_halt, launch;

    inst_branch_decode #(.INST_W(INST_W), .OFF_W(OFF_W)) u_dec (
        .inst      (inst),
        .cond_flag (cond_flag),
        .is_branch (is_branch),
        .is_taken  (is_taken),
        .is_halt   (is_halt),
        .offset    (offset)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        launch  = go & ~go_q;
        start   = state_q == LAUNCH;
        done    = state_q == HALTED;
        branch  = 1'b0;
        taken   = 1'b0;
        halt    = 1'b1;
        case (state_q)
            IDLE, HALTED: if (launch) begin
                state_d = LAUNCH;
                base_d  = program_base;
            end
            LAUNCH: begin
                halt    = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                branch = is_branch;
                taken  = is_taken;
                halt   = is_halt;
                if (is_halt) state_d = HALTED;
            end
        endcase
    end

    assign start_address = base_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go;
            base_q  <= base_d;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] run_cycles_q;
    logic [7:0]  taken_count_q;
    // Entering LAUNCH is only possible from IDLE/HALTED, so it marks an accepted launch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_cycles_q  <= '0;
            taken_count_q <= '0;
        end else if (state_d == LAUNCH && state_q != LAUNCH) begin
            run_cycles_q  <= '0;
            taken_count_q <= '0;
        end else if (state_q == RUN) begin
            if (run_cycles_q != 16'hFFFF) run_cycles_q <= run_cycles_q + 16'd1;
            if (taken && taken_count_q != 8'hFF) taken_count_q <= taken_count_q + 8'd1;
        end
    end
    assign run_cycles  = run_cycles_q;
    assign taken_count = taken_count_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan plus randomized run against a behavioural model of fetch_ctrl.
module tb_fetch_ctrl;
    logic       clock = 1'b0, reset_n = 1'b0, go = 1'b0, cond_flag = 1'b0;
    logic [6:0] program_base = '0;
    logic [8:0] inst = '0;
    logic       start, branch, taken, halt, done;
    logic [6:0] start_address;
    logic [4:0] offset;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] run_cycles;
    logic [7:0]  taken_count;
`endif
    int n_cmp = 0, n_bad = 0;
    // model: program phase flags, latched base, prior go level, perf counts
    bit         m_start, m_run, m_done, m_prev_go;
    logic [6:0] m_base;
    int         m_cyc, m_tk;

    always #5 clock = ~clock;

    fetch_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .go            (go),
        .program_base  (program_base),
        .inst          (inst),
        .cond_flag     (cond_flag),
        .start         (start),
        .start_address (start_address),
        .branch        (branch),
        .taken         (taken),
        .offset        (offset),
        .halt          (halt),
        .done          (done)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .run_cycles    (run_cycles),
        .taken_count   (taken_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit brc, jmp, hlt;
        brc = inst[8:5] == 4'b1110;
        jmp = inst[8:5] == 4'b1101;
        hlt = inst == 9'h1FF;
        check("start", 32'(start), 32'(m_start));
        check("done", 32'(done), 32'(m_done));
        check("halt", 32'(halt), 32'(m_run ? hlt : !m_start));
        check("branch", 32'(branch), 32'(m_run && (brc || jmp)));
        check("taken", 32'(taken), 32'(m_run && (jmp || (brc && cond_flag))));
        check("offset", 32'(offset), 32'(inst[4:0]));
        check("start_address", 32'(start_address), 32'(m_base));
`ifdef FETCH_CTRL_PERF_EN
        check("run_cycles", 32'(run_cycles), m_cyc);
        check("taken_count", 32'(taken_count), m_tk);
`endif
    endtask

    task automatic model_reset();
        m_start = 0; m_run = 0; m_done = 0; m_prev_go = 0;
        m_base = '0; m_cyc = 0; m_tk = 0;
    endtask

    task automatic model_step();
        bit rise, tk;
        rise = go && !m_prev_go;
        tk = inst[8:5] == 4'b1101 || (inst[8:5] == 4'b1110 && cond_flag);
        if (m_start) begin
            m_start = 0;
            m_run = 1;
        end else if (m_run) begin
            if (m_cyc < 65535) m_cyc++;
            if (tk && m_tk < 255) m_tk++;
            if (inst == 9'h1FF) begin
                m_run = 0;
                m_done = 1;
            end
        end else if (rise) begin
            m_base = program_base;
            m_done = 0;
            m_start = 1;
            m_cyc = 0;
            m_tk = 0;
        end
        m_prev_go = go;
    endtask

    task automatic cycle(input logic g, input logic [6:0] pb, input logic [8:0] in, input logic cf);
        @(negedge clock);
        go = g; program_base = pb; inst = in; cond_flag = cf;
        #1 check_outputs();
        @(posedge clock);
        model_step();
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        go = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [8:0] w;
        model_reset();
        #2 check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) cycle(0, 7'd0, 9'd0, 0);
        cycle(1, 7'd20, 9'd0, 0);
        cycle(0, 7'd20, 9'd0, 0);
        check("launch_addr", 32'(start_address), 32'd20);
        cycle(0, 7'd0, 9'b1110_11110, 1);
        check("brc_off", 32'(offset), 32'h1E);
        cycle(0, 7'd0, 9'b1110_11110, 0);
        cycle(0, 7'd0, 9'b1101_00011, 0);
        cycle(0, 7'd0, 9'h012, 1);
        cycle(1, 7'd0, 9'h1FF, 0);
        repeat (3) cycle(1, 7'd9, 9'd0, 0);
        check("no_relaunch", 32'(done), 32'd1);
        cycle(0, 7'd3, 9'd0, 0);
        cycle(1, 7'd3, 9'd0, 0);
        cycle(0, 7'd3, 9'd0, 0);
        check("relaunch_addr", 32'(start_address), 32'd3);
        cycle(0, 7'd0, 9'h005, 0);
        @(negedge clock);
        inst = 9'b1110_00001; cond_flag = 1'b1;
        async_reset();
        cycle(0, 7'd0, 9'd0, 0);
        // 5 RUN cycles with 2 taken jumps, then HALT counts as a 6th RUN cycle
        cycle(1, 7'd40, 9'd0, 0);
        cycle(0, 7'd40, 9'd0, 0);
        cycle(0, 7'd0, 9'b1101_00010, 0);
        cycle(0, 7'd0, 9'h001, 0);
        cycle(0, 7'd0, 9'b1110_00100, 1);
        cycle(0, 7'd0, 9'b1110_00100, 0);
        cycle(0, 7'd0, 9'h002, 0);
        cycle(0, 7'd0, 9'h1FF, 0);
        cycle(0, 7'd0, 9'd0, 0);
        cycle(0, 7'd0, 9'h1B5, 1);
`ifdef FETCH_CTRL_PERF_EN
        check("perf_run6", 32'(run_cycles), 32'd6);
        check("perf_taken2", 32'(taken_count), 32'd2);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            r = $urandom_range(0, 9);
            w = 9'($urandom_range(0, 511));
            if (r == 0) w = 9'h1FF;
            else if (r < 3) w[8:5] = 4'b1110;
            else if (r == 3) w[8:5] = 4'b1101;
            cycle($urandom_range(0, 3) == 0, 7'($urandom_range(0, 127)), w, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
